ast_frame_sanitizer: RTL
========================

Name: ast_frame_sanitizer

Overview:
- Avalon-ST stage directly upstream of packet_resolver.
- Enforces legal SOP/EOP framing on the incoming stream, so the resolver's length checks and FIFOs only ever see well-formed packets.
- Drops beats received outside a packet.
- Terminates an unterminated packet with a forced EOP when a new SOP arrives.
- Registered output through a two-register (pending + output) pipeline.

Parameters:
- AST_DWIDTH, 64, data bus width in bits; multiple of 8.
- CHANNEL_WIDTH, 1, channel field width.
- EMPTY_WIDTH, $clog2(AST_DWIDTH/8), empty field width; derived, not overridden.

Ports:
- clk_i  input  1  single clock, all logic rising-edge.
- srst_i  input  1  synchronous active-high reset.
- ast_sink_if  avalon_st_if.sink  -  data AST_DWIDTH, valid 1, ready 1 (out), startofpacket 1, endofpacket 1, empty EMPTY_WIDTH, channel CHANNEL_WIDTH.
- ast_src_if  avalon_st_if.src  -  same fields; ready is the input.
- drop_cnt_o  output  16  beats dropped outside a packet (AST_SANITIZER_STATS_EN only).
- trunc_cnt_o  output  16  packets closed with a forced EOP (AST_SANITIZER_STATS_EN only).

Behaviour:
- Reset:
  - State = IDLE, pending register P empty, output register O empty.
  - src valid = 0; src data/sop/eop/empty/channel = 0.
  - Counters = 0.
  - Reset mid-packet discards P and O contents with no forced EOP.
- Handshake:
  - Sink beat accepted when sink valid & sink ready.
  - Source beat taken when src valid & src ready.
  - sink ready = !O_valid | src_ready (O will be free next cycle).
  - sink ready does not depend on sink valid.
  - src outputs come straight from O, fully registered.
- FSM IDLE:
  - Accepted beat with sop=1 is stored in P; go IN_PKT.
  - If that beat also has eop=1, stay IDLE.
  - Accepted beat with sop=0 is dropped; drop_cnt increments.
- FSM IN_PKT:
  - Accepted beat, sop=0: P moves to O unchanged; new beat goes into P; eop=1 → IDLE.
  - Accepted beat, sop=1 (framing error): P moves to O with eop forced 1 and empty forced 0; trunc_cnt increments; new beat goes into P; state stays IN_PKT (or IDLE if the new beat has eop).
- P release:
  - A P holding eop=1 moves to O on the first cycle O is free, without waiting for another sink beat.
  - A P with eop=0 waits for the next accepted beat.
  - A P transfer and a new P load may happen in the same cycle.
- Width rules:
  - empty is forced to 0 on every non-EOP output beat.
  - channel is taken from the beat itself.
  - data is never modified.
- Latency:
  - Minimum 2 cycles sink→src for an EOP beat.
  - A non-EOP beat leaves only after its successor arrives.
- Throughput: 1 beat/cycle sustained with src ready held high.
- Backpressure: src ready low holds O stable (all fields) and deasserts sink ready; no beat is lost or duplicated.
- Simultaneous events:
  - O drain and O reload in the same cycle is legal.
  - A counter increment and srst in the same cycle: reset wins.
- Unterminated packet with no following SOP stays held in P indefinitely; no timeout.

Optional Feature:
- AST_SANITIZER_STATS_EN defined:
  - drop_cnt_o and trunc_cnt_o are present.
  - Both are 16-bit, saturate at 16'hFFFF, and clear only on srst_i.
- Not defined: both ports and the counter logic are absent; data path behaviour is identical.

Test Plan:
- Clean 10-beat packet, sop on beat 0, eop+empty=3 on beat 9, src ready=1 → 10 identical beats out, first output 2 cycles after beat 0, empty=3 on last, counters 0.
- 3 beats with sop=0 while IDLE, then a 4-beat packet → only 4 beats out, drop_cnt=3.
- 5 beats of packet A without eop, then sop of packet B (8 beats) → A's beat 4 out with eop=1, empty=0; B intact; trunc_cnt=1.
- Single beat sop=eop=1, empty=7 → one beat out with sop=eop=1, empty=7; then IDLE.
- 190-beat packet with src ready toggling 1/0 every cycle → all 190 beats in order, O stable while ready low, sink ready low whenever O is full and src ready is low.
- srst_i asserted at beat 4 of a 10-beat packet, then a fresh 8-beat packet → src valid=0 the cycle after reset, counters 0, only the fresh 8 beats out.

Source files
------------

// File: rtl/ast_frame_sanitizer.sv
// ast_frame_sanitizer
//   Avalon-ST framing cleanup stage. Beats arriving outside a packet are
//   dropped; a packet left open when a new SOP arrives is closed with a
//   forced EOP. Beats pass through a pending register (P) and an output
//   register (O). A non-EOP beat waits in P until its successor arrives,
//   so that a truncating SOP can still rewrite its EOP/empty fields.
//
// Ports:
//   clk_i, srst_i              clock, synchronous active-high reset
//   ast_sink_*                 Avalon-ST sink (ready is an output)
//   ast_src_*                  Avalon-ST source, driven only from O
//   drop_cnt_o, trunc_cnt_o    saturating 16-bit statistics, present only
//                              when AST_SANITIZER_STATS_EN is defined
module ast_frame_sanitizer #(
  parameter  int AST_DWIDTH    = 64,
  parameter  int CHANNEL_WIDTH = 1,
  localparam int EMPTY_WIDTH   = $clog2(AST_DWIDTH / 8)
) (
  input  logic                     clk_i,
  input  logic                     srst_i,

  input  logic [AST_DWIDTH-1:0]    ast_sink_data_i,
  input  logic                     ast_sink_valid_i,
  output logic                     ast_sink_ready_o,
  input  logic                     ast_sink_startofpacket_i,
  input  logic                     ast_sink_endofpacket_i,
  input  logic [EMPTY_WIDTH-1:0]   ast_sink_empty_i,
  input  logic [CHANNEL_WIDTH-1:0] ast_sink_channel_i,

`ifdef AST_SANITIZER_STATS_EN
  output logic [15:0]              drop_cnt_o,
  output logic [15:0]              trunc_cnt_o,
`endif

  output logic [AST_DWIDTH-1:0]    ast_src_data_o,
  output logic                     ast_src_valid_o,
  input  logic                     ast_src_ready_i,
  output logic                     ast_src_startofpacket_o,
  output logic                     ast_src_endofpacket_o,
  output logic [EMPTY_WIDTH-1:0]   ast_src_empty_o,
  output logic [CHANNEL_WIDTH-1:0] ast_src_channel_o
);

  typedef enum logic {IDLE, IN_PKT} state_e;

  typedef struct packed {
    logic [AST_DWIDTH-1:0]    data;
    logic                     sop;
    logic                     eop;
    logic [EMPTY_WIDTH-1:0]   empty;
    logic [CHANNEL_WIDTH-1:0] channel;
  } beat_t;

  state_e state_q, state_d;
  beat_t  p_q, p_d, o_q, o_d;
  logic   p_valid_q, p_valid_d, o_valid_q, o_valid_d;

  beat_t  in_beat, o_next;
  logic   o_free, accept, in_pkt, trunc, move_p, load_p;

  assign in_beat = '{data:    ast_sink_data_i,
                     sop:     ast_sink_startofpacket_i,
                     eop:     ast_sink_endofpacket_i,
                     empty:   ast_sink_empty_i,
                     channel: ast_sink_channel_i};

  // O is free next cycle if it is empty now or being taken now.
  assign o_free = !o_valid_q | ast_src_ready_i;
  assign accept = ast_sink_valid_i & o_free;
  assign in_pkt = (state_q == IN_PKT);
  assign trunc  = accept & in_pkt & ast_sink_startofpacket_i;
  // An EOP in P leaves as soon as O frees up; a non-EOP one needs a successor.
  // Every accept implies o_free, so P always vacates when a new beat lands.
  assign move_p = p_valid_q & o_free & (p_q.eop | accept);
  assign load_p = accept & (in_pkt | ast_sink_startofpacket_i);

  // State register
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q   <= IDLE;
      p_valid_q <= 1'b0;
      o_valid_q <= 1'b0;
      p_q       <= '0;
      o_q       <= '0;
    end else begin
      state_q   <= state_d;
      p_valid_q <= p_valid_d;
      o_valid_q <= o_valid_d;
      p_q       <= p_d;
      o_q       <= o_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (accept && ast_sink_startofpacket_i && !ast_sink_endofpacket_i)
                state_d = IN_PKT;
      IN_PKT: if (accept && ast_sink_endofpacket_i)
                state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath / output logic
  always_comb begin
    o_next = p_q;
    if (trunc) begin
      o_next.eop   = 1'b1;
      o_next.empty = '0;
    end else if (!p_q.eop) begin
      o_next.empty = '0;
    end

    o_valid_d = o_valid_q;
    o_d       = o_q;
    if (move_p) begin
      o_valid_d = 1'b1;
      o_d       = o_next;
    end else if (ast_src_ready_i) begin
      o_valid_d = 1'b0;
    end

    p_valid_d = p_valid_q;
    p_d       = p_q;
    if (load_p) begin
      p_valid_d = 1'b1;
      p_d       = in_beat;
    end else if (move_p) begin
      p_valid_d = 1'b0;
    end
  end

  assign ast_sink_ready_o        = o_free;
  assign ast_src_valid_o         = o_valid_q;
  assign ast_src_data_o          = o_q.data;
  assign ast_src_startofpacket_o = o_q.sop;
  assign ast_src_endofpacket_o   = o_q.eop;
  assign ast_src_empty_o         = o_q.empty;
  assign ast_src_channel_o       = o_q.channel;

`ifdef AST_SANITIZER_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d, trunc_cnt_q, trunc_cnt_d;
  logic        drop_evt;

  assign drop_evt = accept & !in_pkt & !ast_sink_startofpacket_i;

  always_comb begin
    drop_cnt_d  = drop_cnt_q;
    trunc_cnt_d = trunc_cnt_q;
    if (drop_evt && (drop_cnt_q != '1))
      drop_cnt_d = drop_cnt_q + 16'd1;
    if (trunc && (trunc_cnt_q != '1))
      trunc_cnt_d = trunc_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      drop_cnt_q  <= '0;
      trunc_cnt_q <= '0;
    end else begin
      drop_cnt_q  <= drop_cnt_d;
      trunc_cnt_q <= trunc_cnt_d;
    end
  end

  assign drop_cnt_o  = drop_cnt_q;
  assign trunc_cnt_o = trunc_cnt_q;
`endif

endmodule
